// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation encoding and datapath width.
// Optional shifter is selected with the ALU_SHIFT_EN macro in alu.sv.
package alu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_NOR  = 4'b1100
    } alu_op_t;

endpackage

// File: rtl/alu_shifter.sv
// Purpose: combinational 64-bit barrel shifter (SLL/SRL/SRA); built only when ALU_SHIFT_EN is defined.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the result follows the inputs.
`ifdef ALU_SHIFT_EN
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [5:0]      i_shamt,
    input  alu_op_t         i_op,
    output logic [XLEN-1:0] o_shift
);

    always_comb begin
        o_shift = '0;
        case (i_op)
            ALU_SLL: o_shift = i_a << i_shamt;
            ALU_SRL: o_shift = i_a >> i_shamt;
            ALU_SRA: o_shift = $unsigned($signed(i_a) >>> i_shamt);
            default: o_shift = '0;
        endcase
    end

endmodule
`endif

// File: rtl/alu.sv
// Purpose: 64-bit execute-stage ALU with registered result and zero flag; shifts need ALU_SHIFT_EN.
// Latency: 1 cycle from sampled inputs to ALUOut/Zero; synchronous active-high reset forces 0/1.
// Backpressure: none; accepts a new operation every cycle.
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      ALUctl,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] ALUOut,
    output logic            Zero
);

    alu_op_t         w_op;
    logic [XLEN-1:0] w_result;
    logic            w_zero;
    logic            w_slt;
    logic            w_sltu;
    logic [XLEN-1:0] r_result;
    logic            r_zero;

    assign w_op   = alu_op_t'(ALUctl);
    assign w_slt  = $signed(A) < $signed(B);
    assign w_sltu = A < B;

`ifdef ALU_SHIFT_EN
    logic [XLEN-1:0] w_shift;

    alu_shifter u_shifter (
        .i_a     (A),
        .i_shamt (B[5:0]),
        .i_op    (w_op),
        .o_shift (w_shift)
    );
`endif

    // Unused codes (and shift codes without the shifter) fall to zero.
    always_comb begin
        w_result = '0;
        case (w_op)
            ALU_AND:  w_result = A & B;
            ALU_OR:   w_result = A | B;
            ALU_ADD:  w_result = A + B;
            ALU_SUB:  w_result = A - B;
            ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, w_slt};
            ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, w_sltu};
            ALU_XOR:  w_result = A ^ B;
            ALU_NOR:  w_result = ~(A | B);
`ifdef ALU_SHIFT_EN
            ALU_SLL, ALU_SRL, ALU_SRA: w_result = w_shift;
`endif
            default:  w_result = '0;
        endcase
    end

    assign w_zero = (w_result == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_result;
            r_zero   <= w_zero;
        end
    end

    assign ALUOut = r_result;
    assign Zero   = r_zero;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; shift vectors depend on ALU_SHIFT_EN.
module tb_alu;
    import alu_pkg::*;

    logic            clk;
    logic            reset;
    logic [3:0]      ALUctl;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] ALUOut;
    logic            Zero;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    alu dut (
        .clk    (clk),
        .reset  (reset),
        .ALUctl (ALUctl),
        .A      (A),
        .B      (B),
        .ALUOut (ALUOut),
        .Zero   (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] exp_out, input logic exp_zero);
        n_cmp++;
        assert (ALUOut === exp_out) else begin
            n_err++;
            $error("FAIL %s ALUOut: got %h expected %h", tag, ALUOut, exp_out);
        end
        n_cmp++;
        assert (Zero === exp_zero) else begin
            n_err++;
            $error("FAIL %s Zero: got %b expected %b", tag, Zero, exp_zero);
        end
    endtask

    // Drive inputs, clock one edge, sample 1 time unit later and compare.
    task automatic step(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_out, input logic exp_zero);
        ALUctl = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
        check(tag, exp_out, exp_zero);
    endtask

    initial begin
        reset  = 1'b1;
        ALUctl = ALU_ADD;
        A      = 64'd5;
        B      = 64'd3;

        // Reset held for two edges with ADD 5+3 applied.
        @(posedge clk); #1;
        check("reset_edge1", 64'd0, 1'b1);
        @(posedge clk); #1;
        check("reset_edge2", 64'd0, 1'b1);

        reset = 1'b0;
        step("add_5_3_after_reset", ALU_ADD, 64'd5, 64'd3, 64'd8, 1'b0);

        step("add_0_0",    ALU_ADD, 64'd0, 64'd0, 64'd0, 1'b1);
        step("add_0_1",    ALU_ADD, 64'd0, 64'd1, 64'd1, 1'b0);
        step("add_wrap",   ALU_ADD, ONES,  64'd1, 64'd0, 1'b1);
        step("add_maxpos", ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, MSB, 1'b0);

        step("sub_128_64",  ALU_SUB, 64'd128, 64'd64,  64'd64, 1'b0);
        step("sub_128_32",  ALU_SUB, 64'd128, 64'd32,  64'd96, 1'b0);
        step("sub_128_128", ALU_SUB, 64'd128, 64'd128, 64'd0,  1'b1);
        step("sub_0_1",     ALU_SUB, 64'd0,   64'd1,   ONES,   1'b0);

        step("and", ALU_AND, 64'hF0, 64'h3C, 64'h30, 1'b0);
        step("or",  ALU_OR,  64'hF0, 64'h3C, 64'hFC, 1'b0);
        step("xor", ALU_XOR, 64'hF0, 64'h3C, 64'hCC, 1'b0);
        step("nor", ALU_NOR, 64'd0,  64'd0,  ONES,   1'b0);

        step("slt_m1_1",  ALU_SLT,  ONES, 64'd1, 64'd1, 1'b0);
        step("sltu_m1_1", ALU_SLTU, ONES, 64'd1, 64'd0, 1'b1);
        step("slt_1_m1",  ALU_SLT,  64'd1, ONES, 64'd0, 1'b1);

`ifdef ALU_SHIFT_EN
        step("sll_1_63",  ALU_SLL, 64'd1,  64'd63, MSB,    1'b0);
        step("sra_msb63", ALU_SRA, MSB,    64'd63, ONES,   1'b0);
        step("srl_b64",   ALU_SRL, MSB,    64'd64, MSB,    1'b0);
        step("srl_f0_4",  ALU_SRL, 64'hF0, 64'd4,  64'h0F, 1'b0);
        step("srl_msb63", ALU_SRL, MSB,    64'd63, 64'd1,  1'b0);
`else
        step("sll_off", ALU_SLL, 64'd1, 64'd63, 64'd0, 1'b1);
        step("srl_off", ALU_SRL, MSB,   64'd4,  64'd0, 1'b1);
        step("sra_off", ALU_SRA, MSB,   64'd4,  64'd0, 1'b1);
`endif

        // Back-to-back ops; inputs changed mid-cycle must not disturb outputs.
        step("lat_add_1_1", ALU_ADD, 64'd1, 64'd1, 64'd2, 1'b0);
        ALUctl = ALU_SUB;
        A      = 64'd9;
        B      = 64'd9;
        #3;
        check("lat_hold", 64'd2, 1'b0);
        @(posedge clk); #1;
        check("lat_sub_9_9", 64'd0, 1'b1);

        step("unused_1111", 4'b1111, 64'd7, 64'd9, 64'd0, 1'b1);

        // Mid-stream reset overrides an active operation.
        reset = 1'b1;
        step("reset_mid", ALU_ADD, 64'd5, 64'd3, 64'd0, 1'b1);
        reset = 1'b0;
        step("after_reset_or", ALU_OR, 64'h1, 64'h2, 64'h3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
